dcache_sram_nway: RTL and testbench
===================================

Name: dcache_sram_nway

Overview:
Parametrised N-way set-associative data-cache storage array with per-way valid/dirty bits and true-LRU replacement (age counters).
- Sits between the dcache controller and the line-fill/write-back path.
- Lookup is combinational. On a miss it presents the victim line and its dirty flag so the controller can write back before refill.
- Adds a flush/invalidate sweep engine that streams dirty lines out over a valid/ready handshake.

Parameters:
- SETS, 16, number of sets (power of 2, ≥2); IDX_W = log2(SETS)
- WAYS, 2, associativity (power of 2, 1..8); AGE_W = max(1, log2(WAYS))
- TAG_W, 25, tag width
- LINE_W, 256, line width in bits

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- addr_i  in  IDX_W  set index
- tag_i  in  TAG_W  lookup/write tag
- data_i  in  LINE_W  write line
- enable_i  in  1  access request
- write_i  in  1  1 = write, 0 = read
- dirty_i  in  1  dirty value stored on write (1 = CPU write hit, 0 = refill)
- tag_o  out  TAG_W  hit way tag, or victim tag on miss
- data_o  out  LINE_W  hit way line, or victim line on miss
- hit_o  out  1  valid way with matching tag exists
- valid_o  out  1  selected way valid
- dirty_o  out  1  selected way dirty
- flush_i  in  1  start sweep (single-cycle pulse)
- flush_inv_i  in  1  sampled with flush_i; 1 = also invalidate
- busy_o  out  1  sweep in progress
- wb_valid_o  out  1  write-back line available
- wb_ready_i  in  1  write-back accepted
- wb_idx_o  out  IDX_W  write-back set
- wb_tag_o  out  TAG_W  write-back tag
- wb_data_o  out  LINE_W  write-back line
- flush_done_o  out  1  one-cycle pulse at sweep end

Behaviour:
- Reset (async): all valid = 0, dirty = 0; way w age = w; FSM = IDLE; busy_o, wb_valid_o, flush_done_o = 0. Tag/data arrays are not reset.
- Hit: hit_o = OR over ways of (valid & tag == tag_i) at addr_i. Combinational, valid whenever addr_i/tag_i are stable, independent of enable_i. Duplicate tags cannot occur; the lowest matching way is selected.
- Selected way:
  - hit → the hit way;
  - otherwise the lowest-index invalid way;
  - otherwise the way with age == WAYS-1 (LRU).
  - tag_o, data_o, valid_o, dirty_o reflect the selected way combinationally.
- Write (enable_i & write_i & !busy_o), at the clock edge: selected way gets tag ← tag_i, data ← data_i, valid ← 1, dirty ← dirty_i.
- Read (enable_i & !write_i & !busy_o): no array change.
- LRU touch on any write, and on a read with hit_o:
  - touched way age ← 0;
  - every way in the set with age < old touched age increments by 1;
  - ages within a set stay a permutation of 0..WAYS-1;
  - WAYS = 1: age is constant 0.
- enable_i while busy_o is ignored (no update, no LRU touch); outputs still reflect lookup.
- Sweep FSM:
  - IDLE: flush_i → SCAN; index (set, way) = (0, 0); latch flush_inv_i; busy_o = 1 from the next cycle.
  - SCAN: inspects one entry per cycle.
    - valid & dirty → WB, with wb_idx/tag/data registered from that entry.
    - else: if inv, clear valid; advance.
    - after the last entry (SETS-1, WAYS-1) → DONE.
  - WB: wb_valid_o = 1; outputs held stable until wb_ready_i.
    - on handshake, clear dirty (and valid if inv), then advance/return to SCAN, or → DONE if last.
    - wb_ready_i asserted with wb_valid_o low has no effect.
  - DONE: flush_done_o = 1 for one cycle, busy_o = 0 next cycle → IDLE.
- Flush latency with no dirty lines: busy_o high for SETS*WAYS + 1 cycles.
- LRU ages are untouched by the sweep.
- flush_i while busy is ignored.
- flush_i and an access in the same IDLE cycle: the access completes; the sweep starts next cycle.
- rst_i mid-sweep: immediate IDLE, wb_valid_o drops, pending line is lost.

Decomposition:
- Package dcache_pkg: default SETS/WAYS/TAG_W/LINE_W constants, sweep state enum (IDLE, SCAN, WB, DONE), clog2-based width helpers.
- Sub-module dcache_lru_ages: per-set age vector in, touched way in → next age vector and LRU way out. Purely combinational, instantiated once on the addressed set.

Test Plan:
(all with SETS=16, WAYS=4)
- Refill, then read: write set 3, tag 0x1ABC, data 0xA5.., dirty_i = 0 → read same tag gives hit_o = 1, data_o = 0xA5.., dirty_o = 0. Read tag 0x1ABD gives hit_o = 0, valid_o = 0.
- Fill and evict: write tags 1, 2, 3, 4 into set 5, read-hit tag 1, write tag 5 → tag 2 evicted. Before that write, miss lookup shows tag_o = 2. Afterwards tag 1 hits and tag 2 misses.
- Dirty victim: write tag 7, dirty_i = 1, into set 0, then fill ways until tag 7 is LRU → miss lookup gives tag_o = 7, dirty_o = 1, valid_o = 1.
- Flush with back-pressure: dirty lines at (2, way 1) and (9, way 3); wb_ready_i low for 3 cycles on the first → two handshakes in index order with stable wb_* during stall. Dirty bits clear, valid stays 1. flush_done_o pulses once; total busy = 64 + 1 + 5 cycles.
- Flush+invalidate: flush_inv_i = 1 with all lines valid and clean → no wb_valid_o, busy 65 cycles. Afterwards every lookup misses with valid_o = 0.
- Reset mid-WB: assert rst_i while wb_valid_o = 1 → busy_o, wb_valid_o, flush_done_o = 0 immediately; all lookups miss after release.

Source files
------------

// File: rtl/dcache_pkg.sv
// Shared constants, sweep-state encoding and width helpers for the n-way dcache storage array.
package dcache_pkg;

    localparam int unsigned DefSets  = 16;
    localparam int unsigned DefWays  = 2;
    localparam int unsigned DefTagW  = 25;
    localparam int unsigned DefLineW = 256;

    typedef enum logic [1:0] {
        StIdle,
        StScan,
        StWb,
        StDone
    } sweep_state_e;

    // Index width that never collapses to zero bits (a 1-way cache still needs a way index).
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dcache_lru_ages.sv
// True-LRU age update for one set.
//   ages_i      : current age of each way (a permutation of 0..WAYS-1)
//   touch_way_i : way being accessed
//   ages_o      : ages after touching touch_way_i
//   lru_way_o   : way whose current age is WAYS-1
module dcache_lru_ages #(
    parameter int unsigned WAYS  = 2,
    parameter int unsigned AGE_W = 1
) (
    input  logic [WAYS-1:0][AGE_W-1:0] ages_i,
    input  logic [AGE_W-1:0]           touch_way_i,
    output logic [WAYS-1:0][AGE_W-1:0] ages_o,
    output logic [AGE_W-1:0]           lru_way_o
);

    localparam logic [AGE_W-1:0] LruAge = AGE_W'(WAYS - 1);

    logic [AGE_W-1:0] old_age;

    always_comb begin
        old_age   = ages_i[touch_way_i];
        ages_o    = ages_i;
        lru_way_o = '0;
        for (int w = 0; w < int'(WAYS); w++) begin
            // Younger ways age by one; older ways keep their age, so the set stays a permutation.
            if (AGE_W'(w) == touch_way_i) begin
                ages_o[w] = '0;
            end else if (ages_i[w] < old_age) begin
                ages_o[w] = ages_i[w] + AGE_W'(1);
            end
            if (ages_i[w] == LruAge) begin
                lru_way_o = AGE_W'(w);
            end
        end
    end

endmodule

// File: rtl/dcache_sram_nway.sv
// N-way set-associative dcache storage with valid/dirty bits, true-LRU ages and a flush sweep.
//   clk_i, rst_i                 : clock, asynchronous active-high reset
//   addr_i, tag_i, data_i        : set index, lookup/write tag, write line
//   enable_i, write_i, dirty_i   : access request, write select, dirty value stored on write
//   tag_o, data_o, hit_o,
//   valid_o, dirty_o             : combinational view of the hit way, else the victim way
//   flush_i, flush_inv_i         : start sweep pulse, invalidate-while-sweeping select
//   busy_o, flush_done_o         : sweep in progress, one-cycle end-of-sweep pulse
//   wb_valid_o, wb_ready_i,
//   wb_idx_o, wb_tag_o, wb_data_o: dirty-line write-back stream
module dcache_sram_nway
    import dcache_pkg::*;
#(
    parameter int unsigned SETS   = DefSets,
    parameter int unsigned WAYS   = DefWays,
    parameter int unsigned TAG_W  = DefTagW,
    parameter int unsigned LINE_W = DefLineW,
    localparam int unsigned IDX_W = clog2_min1(SETS),
    localparam int unsigned AGE_W = clog2_min1(WAYS)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [IDX_W-1:0]  addr_i,
    input  logic [TAG_W-1:0]  tag_i,
    input  logic [LINE_W-1:0] data_i,
    input  logic              enable_i,
    input  logic              write_i,
    input  logic              dirty_i,
    output logic [TAG_W-1:0]  tag_o,
    output logic [LINE_W-1:0] data_o,
    output logic              hit_o,
    output logic              valid_o,
    output logic              dirty_o,
    input  logic              flush_i,
    input  logic              flush_inv_i,
    output logic              busy_o,
    output logic              wb_valid_o,
    input  logic              wb_ready_i,
    output logic [IDX_W-1:0]  wb_idx_o,
    output logic [TAG_W-1:0]  wb_tag_o,
    output logic [LINE_W-1:0] wb_data_o,
    output logic              flush_done_o
);

    logic [TAG_W-1:0]           tag_q   [SETS][WAYS];
    logic [LINE_W-1:0]          data_q  [SETS][WAYS];
    logic [WAYS-1:0]            valid_q [SETS];
    logic [WAYS-1:0]            dirty_q [SETS];
    logic [WAYS-1:0][AGE_W-1:0] age_q   [SETS];

    sweep_state_e      state_q;
    logic [IDX_W-1:0]  scan_set_q;
    logic [AGE_W-1:0]  scan_way_q;
    logic              inv_q, busy_q, wb_valid_q, done_q;
    logic [IDX_W-1:0]  wb_idx_q;
    logic [TAG_W-1:0]  wb_tag_q;
    logic [LINE_W-1:0] wb_data_q;

    // ---------------- lookup and victim selection ----------------
    logic                       hit, any_invalid;
    logic [AGE_W-1:0]           hit_way, inv_way, lru_way, sel_way;
    logic [WAYS-1:0][AGE_W-1:0] ages_next;

    always_comb begin
        hit         = 1'b0;
        any_invalid = 1'b0;
        hit_way     = '0;
        inv_way     = '0;
        // Descending scan so the lowest-index candidate is the last assignment.
        for (int w = int'(WAYS) - 1; w >= 0; w--) begin
            if (valid_q[addr_i][w] && (tag_q[addr_i][w] == tag_i)) begin
                hit     = 1'b1;
                hit_way = AGE_W'(w);
            end
            if (!valid_q[addr_i][w]) begin
                any_invalid = 1'b1;
                inv_way     = AGE_W'(w);
            end
        end
        if (hit) begin
            sel_way = hit_way;
        end else if (any_invalid) begin
            sel_way = inv_way;
        end else begin
            sel_way = lru_way;
        end
    end

    dcache_lru_ages #(
        .WAYS  (WAYS),
        .AGE_W (AGE_W)
    ) u_lru (
        .ages_i      (age_q[addr_i]),
        .touch_way_i (sel_way),
        .ages_o      (ages_next),
        .lru_way_o   (lru_way)
    );

    assign hit_o   = hit;
    assign tag_o   = tag_q[addr_i][sel_way];
    assign data_o  = data_q[addr_i][sel_way];
    assign valid_o = valid_q[addr_i][sel_way];
    assign dirty_o = dirty_q[addr_i][sel_way];

    logic acc_wr, acc_touch;
    assign acc_wr    = enable_i & write_i & ~busy_q;
    assign acc_touch = enable_i & ~busy_q & (write_i | hit);

    // ---------------- sweep control ----------------
    logic scan_valid, scan_dirty, last_way, last_entry;
    logic scan_clr_valid, wb_hs;

    assign scan_valid     = valid_q[scan_set_q][scan_way_q];
    assign scan_dirty     = dirty_q[scan_set_q][scan_way_q];
    assign last_way       = (scan_way_q == AGE_W'(WAYS - 1));
    assign last_entry     = last_way && (scan_set_q == IDX_W'(SETS - 1));
    assign scan_clr_valid = (state_q == StScan) && !(scan_valid && scan_dirty) && inv_q;
    assign wb_hs          = (state_q == StWb) && wb_ready_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            scan_set_q <= '0;
            scan_way_q <= '0;
            inv_q      <= 1'b0;
            busy_q     <= 1'b0;
            wb_valid_q <= 1'b0;
            done_q     <= 1'b0;
            wb_idx_q   <= '0;
            wb_tag_q   <= '0;
            wb_data_q  <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (flush_i) begin
                        state_q    <= StScan;
                        scan_set_q <= '0;
                        scan_way_q <= '0;
                        inv_q      <= flush_inv_i;
                        busy_q     <= 1'b1;
                    end
                end
                StScan: begin
                    if (scan_valid && scan_dirty) begin
                        state_q    <= StWb;
                        wb_valid_q <= 1'b1;
                        wb_idx_q   <= scan_set_q;
                        wb_tag_q   <= tag_q[scan_set_q][scan_way_q];
                        wb_data_q  <= data_q[scan_set_q][scan_way_q];
                    end else if (last_entry) begin
                        state_q <= StDone;
                        done_q  <= 1'b1;
                    end else if (last_way) begin
                        scan_way_q <= '0;
                        scan_set_q <= scan_set_q + IDX_W'(1);
                    end else begin
                        scan_way_q <= scan_way_q + AGE_W'(1);
                    end
                end
                StWb: begin
                    if (wb_ready_i) begin
                        wb_valid_q <= 1'b0;
                        if (last_entry) begin
                            state_q <= StDone;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= StScan;
                            if (last_way) begin
                                scan_way_q <= '0;
                                scan_set_q <= scan_set_q + IDX_W'(1);
                            end else begin
                                scan_way_q <= scan_way_q + AGE_W'(1);
                            end
                        end
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // ---------------- state arrays ----------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int s = 0; s < int'(SETS); s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                for (int w = 0; w < int'(WAYS); w++) begin
                    age_q[s][w] <= AGE_W'(w);
                end
            end
        end else begin
            if (acc_wr) begin
                valid_q[addr_i][sel_way] <= 1'b1;
                dirty_q[addr_i][sel_way] <= dirty_i;
            end
            if (acc_touch) begin
                age_q[addr_i] <= ages_next;
            end
            if (scan_clr_valid) begin
                valid_q[scan_set_q][scan_way_q] <= 1'b0;
            end
            if (wb_hs) begin
                dirty_q[scan_set_q][scan_way_q] <= 1'b0;
                if (inv_q) begin
                    valid_q[scan_set_q][scan_way_q] <= 1'b0;
                end
            end
        end
    end

    // Tag and data storage carry no reset; valid bits gate every use.
    always_ff @(posedge clk_i) begin
        if (acc_wr) begin
            tag_q[addr_i][sel_way]  <= tag_i;
            data_q[addr_i][sel_way] <= data_i;
        end
    end

    assign busy_o       = busy_q;
    assign wb_valid_o   = wb_valid_q;
    assign wb_idx_o     = wb_idx_q;
    assign wb_tag_o     = wb_tag_q;
    assign wb_data_o    = wb_data_q;
    assign flush_done_o = done_q;

endmodule

// File: tb/tb_dcache_sram_nway.sv
// Self-checking bench for dcache_sram_nway (SETS=16, WAYS=4): lookup, LRU eviction,
// dirty victims, flush with back-pressure, flush+invalidate, same-cycle access/flush, reset mid-WB.
module tb_dcache_sram_nway;

    localparam int unsigned SETS   = 16;
    localparam int unsigned WAYS   = 4;
    localparam int unsigned TAG_W  = 25;
    localparam int unsigned LINE_W = 256;
    localparam int unsigned IDX_W  = 4;

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b1;
    logic [IDX_W-1:0]  addr_i = '0;
    logic [TAG_W-1:0]  tag_i = '0;
    logic [LINE_W-1:0] data_i = '0;
    logic              enable_i = 1'b0, write_i = 1'b0, dirty_i = 1'b0;
    logic [TAG_W-1:0]  tag_o;
    logic [LINE_W-1:0] data_o;
    logic              hit_o, valid_o, dirty_o;
    logic              flush_i = 1'b0, flush_inv_i = 1'b0;
    logic              busy_o, wb_valid_o;
    logic              wb_ready_i = 1'b0;
    logic [IDX_W-1:0]  wb_idx_o;
    logic [TAG_W-1:0]  wb_tag_o;
    logic [LINE_W-1:0] wb_data_o;
    logic              flush_done_o;

    dcache_sram_nway #(
        .SETS   (SETS),
        .WAYS   (WAYS),
        .TAG_W  (TAG_W),
        .LINE_W (LINE_W)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .addr_i       (addr_i),
        .tag_i        (tag_i),
        .data_i       (data_i),
        .enable_i     (enable_i),
        .write_i      (write_i),
        .dirty_i      (dirty_i),
        .tag_o        (tag_o),
        .data_o       (data_o),
        .hit_o        (hit_o),
        .valid_o      (valid_o),
        .dirty_o      (dirty_o),
        .flush_i      (flush_i),
        .flush_inv_i  (flush_inv_i),
        .busy_o       (busy_o),
        .wb_valid_o   (wb_valid_o),
        .wb_ready_i   (wb_ready_i),
        .wb_idx_o     (wb_idx_o),
        .wb_tag_o     (wb_tag_o),
        .wb_data_o    (wb_data_o),
        .flush_done_o (flush_done_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [IDX_W-1:0]  idx;
        logic [TAG_W-1:0]  tag;
        logic [LINE_W-1:0] data;
    } wb_t;

    wb_t sb_q[$];
    int  n_cmp = 0;
    int  n_fail = 0;

    function automatic logic [LINE_W-1:0] mk_data(input logic [TAG_W-1:0] t);
        return {8{7'd0, t}};
    endfunction

    task automatic apply_reset();
        @(negedge clk_i);
        rst_i = 1'b1;
        enable_i = 1'b0; write_i = 1'b0; flush_i = 1'b0; wb_ready_i = 1'b0;
        sb_q.delete();
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    // Drives a write; a dirty write is a line the next sweep must return, so it is queued.
    task automatic do_write(input int s, input int t, input logic d);
        wb_t e;
        @(negedge clk_i);
        addr_i = IDX_W'(s); tag_i = TAG_W'(t); data_i = mk_data(TAG_W'(t)); dirty_i = d;
        enable_i = 1'b1; write_i = 1'b1;
        if (d) begin
            e.idx = IDX_W'(s); e.tag = TAG_W'(t); e.data = mk_data(TAG_W'(t));
            sb_q.push_back(e);
        end
        @(posedge clk_i);
        #1;
        enable_i = 1'b0; write_i = 1'b0;
    endtask

    task automatic do_read(input int s, input int t);
        @(negedge clk_i);
        addr_i = IDX_W'(s); tag_i = TAG_W'(t); enable_i = 1'b1; write_i = 1'b0;
        @(posedge clk_i);
        #1;
        enable_i = 1'b0;
    endtask

    task automatic probe(input int s, input int t);
        @(negedge clk_i);
        addr_i = IDX_W'(s); tag_i = TAG_W'(t); enable_i = 1'b0;
        #1;
    endtask

    task automatic start_flush(input logic inv);
        @(negedge clk_i);
        flush_i = 1'b1; flush_inv_i = inv;
        @(posedge clk_i);
        #1;
        flush_i = 1'b0; flush_inv_i = 1'b0;
    endtask

    // Watches one sweep to completion, checking each offered write-back against the queue.
    // The first write-back is held off for stall_first cycles.
    task automatic monitor_sweep(input int stall_first, output int busy_cyc, output int done_cnt,
                                 output int hs_cnt);
        int  stall = 0;
        bit  finished = 0;
        busy_cyc = 0; done_cnt = 0; hs_cnt = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk_i);
            if (busy_o) busy_cyc++;
            if (flush_done_o) done_cnt++;
            if (wb_valid_o) begin
                n_cmp++;
                if (sb_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL wb_unexpected: got idx=%0d tag=%h, expected no write-back",
                             wb_idx_o, wb_tag_o);
                    wb_ready_i = 1'b1;
                end else begin
                    if (wb_idx_o !== sb_q[0].idx || wb_tag_o !== sb_q[0].tag ||
                        wb_data_o !== sb_q[0].data) begin
                        n_fail++;
                        $display("FAIL wb_line: got idx=%0d tag=%h data[31:0]=%h, expected idx=%0d tag=%h data[31:0]=%h",
                                 wb_idx_o, wb_tag_o, wb_data_o[31:0], sb_q[0].idx, sb_q[0].tag,
                                 sb_q[0].data[31:0]);
                    end
                    if (hs_cnt == 0 && stall < stall_first) begin
                        stall++;
                        wb_ready_i = 1'b0;
                    end else begin
                        wb_ready_i = 1'b1;
                        void'(sb_q.pop_front());
                        hs_cnt++;
                    end
                end
            end else begin
                wb_ready_i = 1'b0;
            end
            if (!busy_o && busy_cyc > 0) begin
                finished = 1;
                break;
            end
        end
        wb_ready_i = 1'b0;
        if (!finished) begin
            n_cmp++; n_fail++;
            $display("FAIL sweep_timeout: busy_o still %b after 400 cycles, expected 0", busy_o);
        end
    endtask

    task automatic test_reset();
        n_cmp += 3;
        if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy_o); end
        if (wb_valid_o !== 1'b0) begin
            n_fail++; $display("FAIL reset_wb_valid: got %b want 0", wb_valid_o);
        end
        if (flush_done_o !== 1'b0) begin
            n_fail++; $display("FAIL reset_done: got %b want 0", flush_done_o);
        end
        probe(0, 0);
        n_cmp += 2;
        if (hit_o !== 1'b0) begin n_fail++; $display("FAIL reset_hit: got %b want 0", hit_o); end
        if (valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", valid_o); end
    endtask

    task automatic test_refill_read();
        logic [LINE_W-1:0] pat;
        pat = {8{32'hA5A5A5A5}};
        @(negedge clk_i);
        addr_i = 4'd3; tag_i = 25'h1ABC; data_i = pat; dirty_i = 1'b0;
        enable_i = 1'b1; write_i = 1'b1;
        @(posedge clk_i);
        #1;
        enable_i = 1'b0; write_i = 1'b0;
        probe(3, 'h1ABC);
        n_cmp += 3;
        if (hit_o !== 1'b1) begin n_fail++; $display("FAIL refill_hit: got %b want 1", hit_o); end
        if (data_o !== pat) begin
            n_fail++; $display("FAIL refill_data: got %h want %h", data_o[31:0], pat[31:0]);
        end
        if (dirty_o !== 1'b0) begin n_fail++; $display("FAIL refill_dirty: got %b want 0", dirty_o); end
        probe(3, 'h1ABD);
        n_cmp += 2;
        if (hit_o !== 1'b0) begin n_fail++; $display("FAIL other_tag_hit: got %b want 0", hit_o); end
        if (valid_o !== 1'b0) begin
            n_fail++; $display("FAIL other_tag_valid: got %b want 0", valid_o);
        end
    endtask

    task automatic test_evict();
        for (int t = 1; t <= 4; t++) do_write(5, t, 1'b0);
        do_read(5, 1);
        probe(5, 5);
        n_cmp += 3;
        if (hit_o !== 1'b0) begin n_fail++; $display("FAIL evict_miss: got %b want 0", hit_o); end
        if (tag_o !== 25'd2) begin n_fail++; $display("FAIL evict_victim_tag: got %h want 2", tag_o); end
        if (valid_o !== 1'b1) begin n_fail++; $display("FAIL evict_victim_valid: got %b want 1", valid_o); end
        do_write(5, 5, 1'b0);
        probe(5, 1);
        n_cmp++;
        if (hit_o !== 1'b1) begin n_fail++; $display("FAIL evict_tag1_hit: got %b want 1", hit_o); end
        probe(5, 2);
        n_cmp++;
        if (hit_o !== 1'b0) begin n_fail++; $display("FAIL evict_tag2_gone: got %b want 0", hit_o); end
        probe(5, 5);
        n_cmp++;
        if (hit_o !== 1'b1) begin n_fail++; $display("FAIL evict_tag5_hit: got %b want 1", hit_o); end
    endtask

    task automatic test_dirty_victim();
        do_write(0, 7, 1'b1);
        for (int t = 8; t <= 10; t++) do_write(0, t, 1'b0);
        probe(0, 11);
        n_cmp += 4;
        if (hit_o !== 1'b0) begin n_fail++; $display("FAIL dv_hit: got %b want 0", hit_o); end
        if (tag_o !== 25'd7) begin n_fail++; $display("FAIL dv_tag: got %h want 7", tag_o); end
        if (dirty_o !== 1'b1) begin n_fail++; $display("FAIL dv_dirty: got %b want 1", dirty_o); end
        if (valid_o !== 1'b1) begin n_fail++; $display("FAIL dv_valid: got %b want 1", valid_o); end
    endtask

    task automatic test_flush_backpressure();
        int busy_cyc, done_cnt, hs_cnt;
        apply_reset();
        do_write(2, 'h20, 1'b0);
        do_write(2, 'h21, 1'b1);
        for (int t = 'h90; t <= 'h92; t++) do_write(9, t, 1'b0);
        do_write(9, 'h93, 1'b1);
        start_flush(1'b0);
        monitor_sweep(3, busy_cyc, done_cnt, hs_cnt);
        n_cmp += 4;
        if (busy_cyc != 70) begin n_fail++; $display("FAIL bp_busy_cycles: got %0d want 70", busy_cyc); end
        if (done_cnt != 1) begin n_fail++; $display("FAIL bp_done_pulses: got %0d want 1", done_cnt); end
        if (hs_cnt != 2) begin n_fail++; $display("FAIL bp_handshakes: got %0d want 2", hs_cnt); end
        if (sb_q.size() != 0) begin
            n_fail++; $display("FAIL bp_pending: got %0d lines left want 0", sb_q.size());
        end
        probe(2, 'h21);
        n_cmp += 2;
        if (hit_o !== 1'b1) begin n_fail++; $display("FAIL bp_line2_hit: got %b want 1", hit_o); end
        if (dirty_o !== 1'b0) begin n_fail++; $display("FAIL bp_line2_dirty: got %b want 0", dirty_o); end
        probe(9, 'h93);
        n_cmp += 2;
        if (hit_o !== 1'b1) begin n_fail++; $display("FAIL bp_line9_hit: got %b want 1", hit_o); end
        if (dirty_o !== 1'b0) begin n_fail++; $display("FAIL bp_line9_dirty: got %b want 0", dirty_o); end
    endtask

    task automatic test_flush_inv();
        int busy_cyc, done_cnt, hs_cnt;
        apply_reset();
        for (int s = 0; s < int'(SETS); s++)
            for (int w = 0; w < int'(WAYS); w++) do_write(s, 'h100 + s * 16 + w, 1'b0);
        start_flush(1'b1);
        monitor_sweep(0, busy_cyc, done_cnt, hs_cnt);
        n_cmp += 3;
        if (busy_cyc != 65) begin n_fail++; $display("FAIL inv_busy_cycles: got %0d want 65", busy_cyc); end
        if (done_cnt != 1) begin n_fail++; $display("FAIL inv_done_pulses: got %0d want 1", done_cnt); end
        if (hs_cnt != 0) begin n_fail++; $display("FAIL inv_handshakes: got %0d want 0", hs_cnt); end
        for (int s = 0; s < int'(SETS); s++) begin
            probe(s, 'h100 + s * 16);
            n_cmp++;
            if (hit_o !== 1'b0 || valid_o !== 1'b0) begin
                n_fail++;
                $display("FAIL inv_lookup set %0d: got hit=%b valid=%b want 0/0", s, hit_o, valid_o);
            end
        end
    endtask

    task automatic test_back_to_back();
        int busy_cyc, done_cnt, hs_cnt;
        wb_t e;
        apply_reset();
        @(negedge clk_i);
        addr_i = 4'd6; tag_i = 25'h66; data_i = mk_data(25'h66); dirty_i = 1'b1;
        enable_i = 1'b1; write_i = 1'b1; flush_i = 1'b1; flush_inv_i = 1'b0;
        e.idx = 4'd6; e.tag = 25'h66; e.data = mk_data(25'h66);
        sb_q.push_back(e);
        @(posedge clk_i);
        #1;
        enable_i = 1'b0; write_i = 1'b0; flush_i = 1'b0;
        monitor_sweep(0, busy_cyc, done_cnt, hs_cnt);
        n_cmp += 3;
        if (busy_cyc != 66) begin n_fail++; $display("FAIL b2b_busy_cycles: got %0d want 66", busy_cyc); end
        if (hs_cnt != 1) begin n_fail++; $display("FAIL b2b_handshakes: got %0d want 1", hs_cnt); end
        if (done_cnt != 1) begin n_fail++; $display("FAIL b2b_done_pulses: got %0d want 1", done_cnt); end
        probe(6, 'h66);
        n_cmp += 2;
        if (hit_o !== 1'b1) begin n_fail++; $display("FAIL b2b_hit: got %b want 1", hit_o); end
        if (dirty_o !== 1'b0) begin n_fail++; $display("FAIL b2b_dirty: got %b want 0", dirty_o); end
    endtask

    task automatic test_reset_mid_wb();
        bit seen = 0;
        apply_reset();
        do_write(4, 'h44, 1'b1);
        sb_q.delete();
        start_flush(1'b0);
        for (int cyc = 0; cyc < 200; cyc++) begin
            @(negedge clk_i);
            if (wb_valid_o) begin seen = 1; break; end
        end
        n_cmp++;
        if (!seen) begin
            n_fail++; $display("FAIL rst_wb_reached: got wb_valid_o=0 after 200 cycles want 1");
        end
        // An access while busy must be ignored.
        do_write(1, 'h11, 1'b0);
        probe(1, 'h11);
        n_cmp += 3;
        if (hit_o !== 1'b0) begin n_fail++; $display("FAIL busy_write_ignored: got hit=%b want 0", hit_o); end
        if (wb_valid_o !== 1'b1) begin n_fail++; $display("FAIL wb_held: got %b want 1", wb_valid_o); end
        if (wb_tag_o !== 25'h44) begin n_fail++; $display("FAIL wb_tag_held: got %h want 44", wb_tag_o); end
        @(negedge clk_i);
        rst_i = 1'b1;
        #1;
        n_cmp += 3;
        if (busy_o !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy_o); end
        if (wb_valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_wb_valid: got %b want 0", wb_valid_o); end
        if (flush_done_o !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b want 0", flush_done_o); end
        @(negedge clk_i);
        rst_i = 1'b0;
        probe(4, 'h44);
        n_cmp++;
        if (hit_o !== 1'b0 || valid_o !== 1'b0) begin
            n_fail++; $display("FAIL rst_lookup: got hit=%b valid=%b want 0/0", hit_o, valid_o);
        end
    endtask

    initial begin
        apply_reset();
        test_reset();
        test_refill_read();
        test_evict();
        test_dirty_victim();
        test_flush_backpressure();
        test_flush_inv();
        test_back_to_back();
        test_reset_mid_wb();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
